// File: rtl/matstore_pkg.sv
// rtl/matstore_pkg.sv - shared constants, slot entry type, FSM states and helpers for the matrix slot allocator
package matstore_pkg;

  localparam int SLOT_WORDS = 25;
  localparam int MAX_DIM    = 5;
  // Age width is sized for the largest supported slot count (16)
  localparam int MAX_SLOTS  = 16;
  localparam int AGE_W      = $clog2(MAX_SLOTS) + 1;
  localparam logic [AGE_W-1:0] AGE_MAX = '1;

  typedef struct packed {
    logic             valid;
    logic [2:0]       m;
    logic [2:0]       n;
    logic [AGE_W-1:0] age;
  } entry_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN_A,
    ST_GRANT,
    ST_WAIT_COMMIT,
    ST_SCAN_L,
    ST_RESULT
  } state_t;

  // A matrix dimension is legal when it lies in 1..MAX_DIM
  function automatic logic dim_legal(input logic [2:0] d);
    return (d != 3'd0) && (d <= 3'(MAX_DIM));
  endfunction

  // Ages stop at all-ones so long-lived entries tie instead of wrapping to young
  function automatic logic [AGE_W-1:0] age_inc(input logic [AGE_W-1:0] a);
    return (a == AGE_MAX) ? a : a + 1'b1;
  endfunction

endpackage

// File: rtl/matstore_slot_table.sv
// rtl/matstore_slot_table.sv - slot entry registers with scanner read port and age/commit/invalidate write logic
module matstore_slot_table
  import matstore_pkg::*;
#(
  parameter int NUM_SLOTS = 16,
  parameter int IDX_W     = $clog2(NUM_SLOTS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] i_rd_idx,
  output logic             o_rd_valid,
  output logic [2:0]       o_rd_m,
  output logic [2:0]       o_rd_n,
  output logic [AGE_W-1:0] o_rd_age,
  input  logic             i_inv_en,
  input  logic [IDX_W-1:0] i_inv_idx,
  input  logic             i_commit_en,
  input  logic             i_touch_en,
  input  logic [IDX_W-1:0] i_upd_idx,
  input  logic [2:0]       i_upd_m,
  input  logic [2:0]       i_upd_n
);

  entry_t r_tab [NUM_SLOTS];
  entry_t w_rd;

  assign w_rd       = r_tab[i_rd_idx];
  assign o_rd_valid = w_rd.valid;
  assign o_rd_m     = w_rd.m;
  assign o_rd_n     = w_rd.n;
  assign o_rd_age   = w_rd.age;

  // Commit and LRU touch both make the target youngest and age every other live entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_SLOTS; k++) begin
        r_tab[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_SLOTS; k++) begin
        if (i_commit_en || i_touch_en) begin
          if (IDX_W'(k) == i_upd_idx) begin
            r_tab[k].age <= '0;
            if (i_commit_en) begin
              r_tab[k].valid <= 1'b1;
              r_tab[k].m     <= i_upd_m;
              r_tab[k].n     <= i_upd_n;
            end
          end else if (r_tab[k].valid) begin
            r_tab[k].age <= age_inc(r_tab[k].age);
          end
        end
        if (i_inv_en && (IDX_W'(k) == i_inv_idx)) begin
          r_tab[k].valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/matrix_slot_allocator.sv
// rtl/matrix_slot_allocator.sv - matrix RAM slot scheduler and lookup resolver; MATSTORE_LRU_EN makes lookup hits refresh ages (LRU eviction)
module matrix_slot_allocator #(
  parameter int NUM_SLOTS  = 16,
  parameter int SLOT_WORDS = matstore_pkg::SLOT_WORDS,
  parameter int PER_DIM    = 2,
  parameter int ADDR_W     = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alloc_req,
  input  logic [2:0]        alloc_m,
  input  logic [2:0]        alloc_n,
  output logic              alloc_ready,
  output logic [ADDR_W-1:0] alloc_base,
  input  logic              commit,
  input  logic              abort,
  input  logic              lookup_req,
  input  logic [2:0]        lookup_m,
  input  logic [2:0]        lookup_n,
  input  logic [1:0]        lookup_id,
  output logic              lookup_valid,
  output logic              lookup_hit,
  output logic [ADDR_W-1:0] lookup_base,
  output logic [1:0]        lookup_count,
  output logic              busy
);
  import matstore_pkg::*;

  localparam int IDX_W = $clog2(NUM_SLOTS);
  localparam int CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] SCAN_END = CNT_W'(NUM_SLOTS);
  localparam logic [CNT_W-1:0] QUOTA    = CNT_W'(PER_DIM);

  function automatic logic [ADDR_W-1:0] slot_base(input logic [IDX_W-1:0] idx);
    return ADDR_W'(idx) * ADDR_W'(SLOT_WORDS);
  endfunction

  state_t r_state, w_next;

  // Pending request flags and their captured operands
  logic       r_pend_a, r_pend_l;
  logic [2:0] r_pa_m, r_pa_n, r_pl_m, r_pl_n;
  logic [1:0] r_pl_id;
  // Operands of the operation currently being scanned/granted
  logic [2:0] r_cur_m, r_cur_n;
  logic [1:0] r_cur_id;

  // Scanner index runs 0..NUM_SLOTS; the final value is the decision step
  logic [CNT_W-1:0] r_idx;
  logic [CNT_W-1:0] r_cnt;
  logic [IDX_W-1:0] r_old_idx, r_sec_idx, r_free_idx, r_glob_idx;
  logic [AGE_W-1:0] r_old_age, r_sec_age, r_glob_age;
  logic             r_free_v, r_glob_v;

  logic [IDX_W-1:0]  r_victim, r_hit_idx;
  logic [ADDR_W-1:0] r_alloc_base, r_lbase;
  logic              r_lhit;
  logic [1:0]        r_lcnt;

  logic             w_alloc_in, w_take_a, w_take_l, w_scan_last, w_scanning, w_same;
  logic             w_inv_en, w_commit_en, w_touch_en, w_lhit;
  logic [IDX_W-1:0] w_victim, w_lhit_idx, w_upd_idx;
  logic             w_rd_valid;
  logic [2:0]       w_rd_m, w_rd_n;
  logic [AGE_W-1:0] w_rd_age;

  assign w_alloc_in  = alloc_req && dim_legal(alloc_m) && dim_legal(alloc_n);
  assign w_take_l    = (r_state == ST_IDLE) && (w_next == ST_SCAN_L);
  assign w_take_a    = (r_state == ST_IDLE) && (w_next == ST_SCAN_A);
  assign w_scan_last = (r_idx == SCAN_END);
  assign w_scanning  = ((r_state == ST_SCAN_A) || (r_state == ST_SCAN_L)) && !w_scan_last;
  assign w_same      = w_rd_valid && (w_rd_m == r_cur_m) && (w_rd_n == r_cur_n);

  // Quota breach reuses the oldest same-dim slot; otherwise first free, else evict globally oldest
  assign w_victim   = (r_cnt >= QUOTA) ? r_old_idx : (r_free_v ? r_free_idx : r_glob_idx);
  assign w_lhit     = ((r_cur_id == 2'd1) && (r_cnt >= CNT_W'(1))) ||
                      ((r_cur_id == 2'd2) && (r_cnt >= CNT_W'(2)));
  assign w_lhit_idx = (r_cur_id == 2'd2) ? r_sec_idx : r_old_idx;
  assign w_upd_idx  = (r_state == ST_RESULT) ? r_hit_idx : r_victim;

  assign alloc_ready  = (r_state == ST_GRANT);
  assign lookup_valid = (r_state == ST_RESULT);
  assign busy         = (r_state != ST_IDLE);
  assign alloc_base   = r_alloc_base;
  assign lookup_hit   = r_lhit;
  assign lookup_base  = r_lbase;
  assign lookup_count = r_lcnt;

  matstore_slot_table #(
    .NUM_SLOTS (NUM_SLOTS)
  ) u_table (
    .clk         (clk),
    .rst         (rst),
    .i_rd_idx    (r_idx[IDX_W-1:0]),
    .o_rd_valid  (w_rd_valid),
    .o_rd_m      (w_rd_m),
    .o_rd_n      (w_rd_n),
    .o_rd_age    (w_rd_age),
    .i_inv_en    (w_inv_en),
    .i_inv_idx   (r_victim),
    .i_commit_en (w_commit_en),
    .i_touch_en  (w_touch_en),
    .i_upd_idx   (w_upd_idx),
    .i_upd_m     (r_cur_m),
    .i_upd_n     (r_cur_n)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Next state and table write strobes; lookups win over allocs when both are waiting
  always_comb begin
    w_next      = r_state;
    w_inv_en    = 1'b0;
    w_commit_en = 1'b0;
    w_touch_en  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_pend_l || lookup_req)      w_next = ST_SCAN_L;
        else if (r_pend_a || w_alloc_in) w_next = ST_SCAN_A;
      end
      ST_SCAN_A: if (w_scan_last) w_next = ST_GRANT;
      ST_GRANT: begin
        w_inv_en = 1'b1;
        w_next   = ST_WAIT_COMMIT;
      end
      ST_WAIT_COMMIT: begin
        if (abort) begin
          w_next = ST_IDLE;
        end else if (commit) begin
          w_commit_en = 1'b1;
          w_next      = ST_IDLE;
        end
      end
      ST_SCAN_L: if (w_scan_last) w_next = ST_RESULT;
      ST_RESULT: begin
`ifdef MATSTORE_LRU_EN
        w_touch_en = r_lhit;
`endif
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Request capture: one pending slot per kind, duplicates dropped; active operands loaded at scan start
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend_a <= 1'b0;
      r_pend_l <= 1'b0;
      r_pa_m   <= '0;
      r_pa_n   <= '0;
      r_pl_m   <= '0;
      r_pl_n   <= '0;
      r_pl_id  <= '0;
      r_cur_m  <= '0;
      r_cur_n  <= '0;
      r_cur_id <= '0;
    end else begin
      if (w_take_l)        r_pend_l <= 1'b0;
      else if (lookup_req) r_pend_l <= 1'b1;
      if (lookup_req && !r_pend_l && !w_take_l) begin
        r_pl_m  <= lookup_m;
        r_pl_n  <= lookup_n;
        r_pl_id <= lookup_id;
      end
      if (w_take_a)        r_pend_a <= 1'b0;
      else if (w_alloc_in) r_pend_a <= 1'b1;
      if (w_alloc_in && !r_pend_a && !w_take_a) begin
        r_pa_m <= alloc_m;
        r_pa_n <= alloc_n;
      end
      if (w_take_l) begin
        r_cur_m  <= r_pend_l ? r_pl_m  : lookup_m;
        r_cur_n  <= r_pend_l ? r_pl_n  : lookup_n;
        r_cur_id <= r_pend_l ? r_pl_id : lookup_id;
      end else if (w_take_a) begin
        r_cur_m  <= r_pend_a ? r_pa_m : alloc_m;
        r_cur_n  <= r_pend_a ? r_pa_n : alloc_n;
        r_cur_id <= '0;
      end
    end
  end

  // Scanner: one slot per cycle, strict '>' keeps the lowest index on age ties
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx      <= '0;
      r_cnt      <= '0;
      r_old_idx  <= '0;
      r_old_age  <= '0;
      r_sec_idx  <= '0;
      r_sec_age  <= '0;
      r_free_v   <= 1'b0;
      r_free_idx <= '0;
      r_glob_v   <= 1'b0;
      r_glob_idx <= '0;
      r_glob_age <= '0;
    end else if (w_take_a || w_take_l) begin
      r_idx    <= '0;
      r_cnt    <= '0;
      r_free_v <= 1'b0;
      r_glob_v <= 1'b0;
    end else if (w_scanning) begin
      r_idx <= r_idx + 1'b1;
      if (w_same) begin
        r_cnt <= r_cnt + 1'b1;
        if ((r_cnt == '0) || (w_rd_age > r_old_age)) begin
          r_sec_idx <= r_old_idx;
          r_sec_age <= r_old_age;
          r_old_idx <= r_idx[IDX_W-1:0];
          r_old_age <= w_rd_age;
        end else if ((r_cnt == CNT_W'(1)) || (w_rd_age > r_sec_age)) begin
          r_sec_idx <= r_idx[IDX_W-1:0];
          r_sec_age <= w_rd_age;
        end
      end
      if (!w_rd_valid && !r_free_v) begin
        r_free_v   <= 1'b1;
        r_free_idx <= r_idx[IDX_W-1:0];
      end
      if (w_rd_valid && (!r_glob_v || (w_rd_age > r_glob_age))) begin
        r_glob_v   <= 1'b1;
        r_glob_idx <= r_idx[IDX_W-1:0];
        r_glob_age <= w_rd_age;
      end
    end
  end

  // Decision step: latch victim/grant base or lookup result; values hold until the next decision
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_victim     <= '0;
      r_alloc_base <= '0;
      r_hit_idx    <= '0;
      r_lhit       <= 1'b0;
      r_lbase      <= '0;
      r_lcnt       <= '0;
    end else if (w_scan_last && (r_state == ST_SCAN_A)) begin
      r_victim     <= w_victim;
      r_alloc_base <= slot_base(w_victim);
    end else if (w_scan_last && (r_state == ST_SCAN_L)) begin
      r_hit_idx <= w_lhit_idx;
      r_lhit    <= w_lhit;
      r_lbase   <= w_lhit ? slot_base(w_lhit_idx) : '0;
      r_lcnt    <= (r_cnt > CNT_W'(3)) ? 2'd3 : r_cnt[1:0];
    end
  end

endmodule

// File: tb/tb_matrix_slot_allocator.sv
// tb/tb_matrix_slot_allocator.sv - directed scoreboard bench for matrix_slot_allocator
module tb_matrix_slot_allocator;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       alloc_req = 1'b0;
  logic [2:0] alloc_m = '0, alloc_n = '0;
  logic       alloc_ready;
  logic [8:0] alloc_base;
  logic       commit = 1'b0, abort = 1'b0;
  logic       lookup_req = 1'b0;
  logic [2:0] lookup_m = '0, lookup_n = '0;
  logic [1:0] lookup_id = '0;
  logic       lookup_valid, lookup_hit;
  logic [8:0] lookup_base;
  logic [1:0] lookup_count;
  logic       busy;

  typedef struct {
    logic       hit;
    logic [8:0] base;
    logic [1:0] cnt;
  } look_exp_t;

  int        alloc_q[$];
  look_exp_t look_q[$];
  int        checks = 0;
  int        errors = 0;

  matrix_slot_allocator dut (
    .clk          (clk),
    .rst          (rst),
    .alloc_req    (alloc_req),
    .alloc_m      (alloc_m),
    .alloc_n      (alloc_n),
    .alloc_ready  (alloc_ready),
    .alloc_base   (alloc_base),
    .commit       (commit),
    .abort        (abort),
    .lookup_req   (lookup_req),
    .lookup_m     (lookup_m),
    .lookup_n     (lookup_n),
    .lookup_id    (lookup_id),
    .lookup_valid (lookup_valid),
    .lookup_hit   (lookup_hit),
    .lookup_base  (lookup_base),
    .lookup_count (lookup_count),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_ready"}, alloc_ready, 0);
    chk({tag, "_abase"}, alloc_base, 0);
    chk({tag, "_lvalid"}, lookup_valid, 0);
    chk({tag, "_lhit"}, lookup_hit, 0);
    chk({tag, "_lbase"}, lookup_base, 0);
    chk({tag, "_lcount"}, lookup_count, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  // Returns in the grant cycle
  task automatic run_alloc(input logic [2:0] m, input logic [2:0] n, input int exp_base, input string tag);
    int lat;
    bit seen;
    int exp_b;
    alloc_q.push_back(exp_base);
    alloc_m = m; alloc_n = n; alloc_req = 1'b1;
    lat = 0; seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      tick();
      lat++;
      alloc_req = 1'b0;
      if (alloc_ready) seen = 1;
    end
    exp_b = alloc_q.pop_front();
    chk({tag, "_seen"}, seen, 1);
    if (seen) begin
      chk({tag, "_lat"}, lat, 18);
      chk({tag, "_base"}, alloc_base, exp_b);
    end
  endtask

  task automatic finish_alloc(input bit do_abort, input string tag);
    tick();
    commit = !do_abort;
    abort  = do_abort;
    tick();
    commit = 1'b0;
    abort  = 1'b0;
    chk({tag, "_idle"}, busy, 0);
  endtask

  // Returns with the DUT back in IDLE
  task automatic run_lookup(input logic [2:0] m, input logic [2:0] n, input logic [1:0] id,
                            input logic hit, input int base, input int cnt, input string tag);
    int lat;
    bit seen;
    look_exp_t e;
    look_q.push_back('{hit, 9'(base), 2'(cnt)});
    lookup_m = m; lookup_n = n; lookup_id = id; lookup_req = 1'b1;
    lat = 0; seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      tick();
      lat++;
      lookup_req = 1'b0;
      if (lookup_valid) seen = 1;
    end
    e = look_q.pop_front();
    chk({tag, "_seen"}, seen, 1);
    if (seen) begin
      chk({tag, "_lat"}, lat, 18);
      chk({tag, "_hit"}, lookup_hit, e.hit);
      chk({tag, "_base"}, lookup_base, e.base);
      chk({tag, "_cnt"}, lookup_count, e.cnt);
    end
    tick();
  endtask

  task automatic run_bad_alloc(input logic [2:0] m, input logic [2:0] n, input string tag);
    int grants;
    alloc_m = m; alloc_n = n; alloc_req = 1'b1;
    tick();
    alloc_req = 1'b0;
    chk({tag, "_busy"}, busy, 0);
    grants = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (alloc_ready) grants++;
    end
    chk({tag, "_grants"}, grants, 0);
  endtask

  logic [2:0] fill_m [14] = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd2, 3'd2, 3'd2, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3, 3'd3};
  logic [2:0] fill_n [14] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd1, 3'd2, 3'd4, 3'd5, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5};

  initial begin
    int t, lv_t, ar_t, exp_b;
    look_exp_t e;

    // Reset
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk_outputs_zero("reset");

    // First alloc goes to slot 0
    run_alloc(3'd2, 3'd3, 0, "a23_first");
    finish_alloc(0, "a23_first_c");
    run_lookup(3'd2, 3'd3, 2'd1, 1'b1, 0, 1, "l23_first");

    // Quota of two per dims: second goes to slot 1, third reuses oldest (slot 0)
    run_alloc(3'd2, 3'd3, 25, "a23_second");
    finish_alloc(0, "a23_second_c");
    run_alloc(3'd2, 3'd3, 0, "a23_third");
    finish_alloc(0, "a23_third_c");
    run_lookup(3'd2, 3'd3, 2'd1, 1'b1, 25, 2, "l23_id1");
    run_lookup(3'd2, 3'd3, 2'd2, 1'b1, 0, 2, "l23_id2");
    run_lookup(3'd2, 3'd3, 2'd3, 1'b0, 0, 2, "l23_id3");
    run_lookup(3'd2, 3'd3, 2'd0, 1'b0, 0, 2, "l23_id0");
    run_lookup(3'd4, 3'd4, 2'd1, 1'b0, 0, 0, "l44_none");

    // Illegal dimensions produce no grant
    run_bad_alloc(3'd0, 3'd3, "bad_m0");
    run_bad_alloc(3'd2, 3'd6, "bad_n6");

    // Fill slots 2..15 with distinct dims
    for (int k = 0; k < 14; k++) begin
      run_alloc(fill_m[k], fill_n[k], (k + 2) * 25, $sformatf("fill%0d", k));
      finish_alloc(0, $sformatf("fill%0d_c", k));
    end

    // Full RAM: victim is slot 1, the earliest commit still live; abort it
    run_alloc(3'd4, 3'd1, 25, "a41_evict");
    finish_alloc(1, "a41_abort");
    run_lookup(3'd2, 3'd3, 2'd1, 1'b1, 0, 1, "l23_after_abort");
    run_lookup(3'd2, 3'd3, 2'd2, 1'b0, 0, 1, "l23_id2_after_abort");

    // Freed slot 1 is reused
    run_alloc(3'd4, 3'd1, 25, "a41_reuse");
    finish_alloc(0, "a41_reuse_c");
    run_lookup(3'd4, 3'd1, 2'd1, 1'b1, 25, 1, "l41");

    // Simultaneous lookup and alloc: lookup served first
    look_q.push_back('{1'b1, 9'd50, 2'd1});
    alloc_q.push_back(0);
    lookup_m = 3'd1; lookup_n = 3'd1; lookup_id = 2'd1; lookup_req = 1'b1;
    alloc_m  = 3'd4; alloc_n  = 3'd2; alloc_req = 1'b1;
    t = 0; lv_t = -1; ar_t = -1;
    for (int i = 0; i < 80 && ar_t < 0; i++) begin
      tick();
      t++;
      lookup_req = 1'b0;
      alloc_req  = 1'b0;
      if (lookup_valid && lv_t < 0) begin
        lv_t = t;
        e = look_q.pop_front();
        chk("both_lhit", lookup_hit, e.hit);
        chk("both_lbase", lookup_base, e.base);
        chk("both_lcnt", lookup_count, e.cnt);
      end
      if (alloc_ready) begin
        ar_t = t;
        exp_b = alloc_q.pop_front();
        chk("both_abase", alloc_base, exp_b);
      end
    end
    chk("both_lv_cycle", lv_t, 18);
    chk("both_ar_cycle", ar_t, 37);
    chk("both_gap", ar_t - lv_t, 19);
    finish_alloc(0, "both_c");
    run_lookup(3'd4, 3'd2, 2'd1, 1'b1, 0, 1, "l42");

    // Reset while waiting for commit abandons the grant
    run_alloc(3'd5, 3'd5, 50, "a55");
    tick();
    chk("a55_waiting", busy, 1);
    rst = 1'b1;
    #2;
    chk("async_rst_busy", busy, 0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    commit = 1'b1;
    tick();
    commit = 1'b0;
    tick();
    chk_outputs_zero("post_rst");
    run_lookup(3'd5, 3'd5, 2'd1, 1'b0, 0, 0, "l55_post_rst");
    run_lookup(3'd2, 3'd3, 2'd1, 1'b0, 0, 0, "l23_post_rst");
    run_lookup(3'd4, 3'd2, 2'd1, 1'b0, 0, 0, "l42_post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/matrix_slot_allocator.md
# matrix_slot_allocator

Storage-address scheduler for the shared matrix RAM. Grants a base address to the input/generation datapath for each new matrix, enforcing a per-dimension quota and evicting old matrices when the RAM is full. Resolves (m, n, id) lookups from the compute FSM into base addresses. Sits between the top-level control FSM, the input subsystem (`base_addr`/`addr_ready` handshake) and the matrix RAM address mux.

## Interface
- `NUM_SLOTS`, 16: matrix slots; slot k base = k*SLOT_WORDS.
- `SLOT_WORDS`, 25: words per slot (5x5 max).
- `PER_DIM`, 2: max live matrices per (m,n); legal values 1..2.
- `ADDR_W`, 9: RAM address width; NUM_SLOTS*SLOT_WORDS <= 2^ADDR_W.

- `clk` in 1: clock.
- `rst` in 1: asynchronous, active-high reset.
- `alloc_req` in 1: pulse; m/n sampled same cycle.
- `alloc_m`, `alloc_n` in 3 each: dims 1..5.
- `alloc_ready` out 1: one-cycle grant pulse.
- `alloc_base` out ADDR_W: granted base; held until commit/abort.
- `commit` in 1: matrix fully written (input done).
- `abort` in 1: write cancelled.
- `lookup_req` in 1: pulse; `lookup_m`, `lookup_n` (3 each), `lookup_id` (2) sampled same cycle.
- `lookup_valid` out 1: one-cycle result pulse.
- `lookup_hit` out 1: entry found; qualified by lookup_valid.
- `lookup_base` out ADDR_W: base of hit entry, 0 on miss.
- `lookup_count` out 2: live entries with the looked-up dims.
- `busy` out 1: high in any state other than IDLE.

## Operation
- Entry per slot: valid, m, n, age (width clog2(NUM_SLOTS)+1, saturating at all-ones).
- Requests are latched into pending flags, with dims/id captured. A second request of the same kind while pending is dropped. Invalid dims (0, >5) on alloc_req: request dropped, no grant.
- States: IDLE, SCAN_A, GRANT, WAIT_COMMIT, SCAN_L, RESULT.
- IDLE: a pending lookup is served before a pending alloc (fixed priority); both → SCAN_L first.
- SCAN_A: one slot per cycle, index 0..NUM_SLOTS-1. Collects: same-dim count, oldest same-dim slot, first free slot, globally oldest valid slot. Age ties are broken by the lowest index.
- Victim selection at end of SCAN_A:
  - same-dim count >= PER_DIM → oldest same-dim slot;
  - else first free slot;
  - else globally oldest slot.
- GRANT: victim entry invalidated; alloc_ready=1; alloc_base=victim*SLOT_WORDS; → WAIT_COMMIT.
- WAIT_COMMIT: lookups stay pending.
  - commit: victim gets valid=1, m, n, age=0; every other valid entry age+1, saturating. → IDLE.
  - abort: victim stays invalid. → IDLE.
  - commit and abort in the same cycle: abort wins.
- SCAN_L: finds same-dim entries. id 1 = oldest, id 2 = second oldest. id 0, or id > count → miss.
- RESULT: lookup_valid=1 with hit/base/count; → IDLE.

## Timing
- Reset values: every output 0; all entries invalid, ages 0; state IDLE; pending flags cleared. Reset mid-operation abandons any grant. No commit is accepted until the next alloc.
- Alloc latency: alloc_req at cycle 0 (state IDLE, nothing pending) → alloc_ready at cycle NUM_SLOTS+2 (SCAN_A occupies cycles 1..NUM_SLOTS, victim decided at NUM_SLOTS+1).
- Lookup latency is identical: lookup_valid at cycle NUM_SLOTS+2.
- commit/abort outside WAIT_COMMIT are ignored.
- alloc_base and lookup_base are registered and stable from the grant/result cycle until the next grant/result.
- Throughput: one operation per NUM_SLOTS+3 cycles.

## Configuration
- `MATSTORE_LRU_EN` defined: a lookup hit resets the hit entry's age to 0 and increments every other valid entry's age, saturating. Eviction becomes LRU.
- Undefined: lookups never modify ages. Eviction is FIFO by commit order.

## Structure
- Package `matstore_pkg`: SLOT_WORDS, MAX_DIM=5, entry struct (valid, m, n, age), state enum, dim-legality function.
- Sub-module `matstore_slot_table`: entry registers, indexed read port for the scanner, and the age-update/commit/invalidate write logic. The scanner FSM and arbitration live in the top module.

## Test plan
- After reset, alloc 2x3 → alloc_ready at cycle 18, base 0. Commit; lookup (2,3,id1) → hit, base 0, count 1.
- Alloc 2x3 three times with commits → bases 0, 25, then 0 again (quota 2, oldest same-dim reused). Lookup (2,3,id1) → base 25; lookup (2,3,id2) → base 0.
- Fill 16 slots with distinct dims, then alloc a 17th → victim is the first-committed slot (FIFO). With MATSTORE_LRU_EN, a prior lookup hit on slot 0 moves the victim to slot 1.
- Alloc then abort → slot invalid. A lookup for the previous occupant's dims → miss, count decremented.
- alloc_req and lookup_req in the same cycle → lookup_valid precedes alloc_ready by NUM_SLOTS+3 cycles.
- Assert rst in WAIT_COMMIT, then commit → ignored; all lookups miss, all outputs 0.
